// File: rtl/avl_bus_pkg.sv
// Shared definitions for the Avalon-style bus bridge slice.
// Holds the command word carried through the bridge FIFO and a helper
// that sizes pointer and counter fields.
//   AVL_ADDR_W / AVL_DATA_W : widths of the fields in avl_cmd_t
//   avl_cmd_t               : {we, addr, wdata, be} command word
//   clog2_safe()            : ceil(log2(n)), never returns less than 1
package avl_bus_pkg;

    localparam int AVL_ADDR_W = 32;
    localparam int AVL_DATA_W = 32;
    localparam int AVL_BE_W   = AVL_DATA_W / 8;

    typedef struct packed {
        logic                  we;
        logic [AVL_ADDR_W-1:0] addr;
        logic [AVL_DATA_W-1:0] wdata;
        logic [AVL_BE_W-1:0]   be;
    } avl_cmd_t;

    // A one-bit field is the narrowest legal vector, so the result is
    // clamped to 1 even for value <= 2.
    function automatic int clog2_safe(input int value);
        int result;
        result = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/avl_sync_fifo.sv
// Synchronous FIFO of avl_cmd_t commands.
// The full and empty flags are registered so that upstream handshake
// logic sees a flop output rather than a comparator chain.
// Ports:
//   clk, rst   : rising-edge clock, asynchronous active-high reset
//   push       : write push_data (ignored while full)
//   push_data  : command to enqueue
//   pop        : drop the head entry (ignored while empty)
//   head       : oldest entry, valid while !empty
//   full/empty : registered occupancy flags
module avl_sync_fifo
    import avl_bus_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     push,
    input  avl_cmd_t push_data,
    input  logic     pop,
    output avl_cmd_t head,
    output logic     full,
    output logic     empty
);

    localparam int PTR_W = clog2_safe(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    avl_cmd_t          mem_q [DEPTH];
    avl_cmd_t          mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              full_q, full_d;
    logic              empty_q, empty_d;
    logic              do_push, do_pop;

    // Pointers wrap naturally because DEPTH is a power of two. The flags
    // are derived from the next count so they are exact on the cycle after
    // every push or pop.
    always_comb begin
        do_push  = push && !full_q;
        do_pop   = pop && !empty_q;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        full_d  = (count_d == CNT_W'(DEPTH));
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign full  = full_q;
    assign empty = empty_q;

endmodule

// File: rtl/avl_bus_pipe_bridge.sv
// Pipelining bridge between one bus-controller slave port and one device.
// Accepted commands are queued in a small FIFO so device wait-states do not
// stall the bus; outstanding reads are counted so no more than
// MAX_PENDING_RD are ever in flight, and read data returns in device order.
// Ports:
//   clk, rest            : rising-edge clock, asynchronous active-high reset
//   s_address .. s_byteenable, s_read, s_write : upstream command
//   s_waitrequest        : upstream command not accepted this cycle
//   s_readdata/valid     : upstream read return
//   m_address .. m_byteenable, m_read, m_write : downstream command
//   m_waitrequest        : device stall
//   m_readdata/valid     : device read return
// Build option:
//   AVL_BUS_PIPE_BRIDGE_RDATA_REG_EN : when defined, the read return path is
//   registered (one cycle of latency); otherwise it is a gated pass-through.
module avl_bus_pipe_bridge
    import avl_bus_pkg::*;
#(
    parameter int ADDR_W         = AVL_ADDR_W,
    parameter int DATA_W         = AVL_DATA_W,
    parameter int FIFO_DEPTH     = 4,
    parameter int MAX_PENDING_RD = 4
) (
    input  logic                clk,
    input  logic                rest,
    input  logic [ADDR_W-1:0]   s_address,
    input  logic                s_read,
    input  logic                s_write,
    input  logic [DATA_W-1:0]   s_writedata,
    input  logic [DATA_W/8-1:0] s_byteenable,
    output logic                s_waitrequest,
    output logic [DATA_W-1:0]   s_readdata,
    output logic                s_readdatavalid,
    output logic [ADDR_W-1:0]   m_address,
    output logic                m_read,
    output logic                m_write,
    output logic [DATA_W-1:0]   m_writedata,
    output logic [DATA_W/8-1:0] m_byteenable,
    input  logic                m_waitrequest,
    input  logic [DATA_W-1:0]   m_readdata,
    input  logic                m_readdatavalid
);

    localparam int                BE_W     = DATA_W / 8;
    localparam int                PEND_W   = clog2_safe(MAX_PENDING_RD + 1);
    localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(MAX_PENDING_RD);

    avl_cmd_t          push_cmd, head_cmd, shown_cmd;
    avl_cmd_t          last_cmd_q, last_cmd_d;
    logic              fifo_full, fifo_empty;
    logic              accept, rd_accept, pop, pending_dec;
    logic [PEND_W-1:0] pending_q, pending_d;
    logic              rst_busy_q, rst_busy_d;

    // Upstream handshake. rst_busy_q keeps the port stalled until the first
    // clock edge after reset is released. A read+write pair is a write.
    always_comb begin
        s_waitrequest = fifo_full || (s_read && pending_q == PEND_MAX) || rest || rst_busy_q;
        accept        = (s_read || s_write) && !s_waitrequest;
        rd_accept     = accept && !s_write;
        push_cmd      = '{we:    s_write,
                          addr:  AVL_ADDR_W'(s_address),
                          wdata: AVL_DATA_W'(s_writedata),
                          be:    AVL_BE_W'(s_byteenable)};
        rst_busy_d    = 1'b0;
    end

    avl_sync_fifo #(
        .DEPTH     (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rest),
        .push      (accept),
        .push_data (push_cmd),
        .pop       (pop),
        .head      (head_cmd),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Device side. When the queue runs dry the address/data buses keep
    // showing the last command issued instead of whatever stale slot the
    // read pointer happens to land on.
    always_comb begin
        pop          = !fifo_empty && !m_waitrequest;
        last_cmd_d   = pop ? head_cmd : last_cmd_q;
        shown_cmd    = fifo_empty ? last_cmd_q : head_cmd;
        m_read       = !fifo_empty && !head_cmd.we;
        m_write      = !fifo_empty && head_cmd.we;
        m_address    = ADDR_W'(shown_cmd.addr);
        m_writedata  = DATA_W'(shown_cmd.wdata);
        m_byteenable = BE_W'(shown_cmd.be);
    end

`ifdef AVL_BUS_PIPE_BRIDGE_RDATA_REG_EN
    logic              rdv_q, rdv_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    // A return already sitting in rdv_q has not yet been subtracted from
    // pending_q, so it is discounted before deciding whether another
    // device return still belongs to an outstanding read.
    always_comb begin
        rdv_d           = m_readdatavalid && (pending_q > PEND_W'(rdv_q));
        rdata_d         = rdv_d ? m_readdata : '0;
        pending_dec     = rdv_q;
        s_readdatavalid = rdv_q;
        s_readdata      = rdata_q;
    end

    always_ff @(posedge clk or posedge rest) begin
        if (rest) begin
            rdv_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            rdv_q   <= rdv_d;
            rdata_q <= rdata_d;
        end
    end
`else
    // Returns with nothing outstanding (e.g. a device answering a read that
    // was discarded by reset) are dropped here.
    always_comb begin
        pending_dec     = m_readdatavalid && (pending_q != '0);
        s_readdatavalid = pending_dec;
        s_readdata      = pending_dec ? m_readdata : '0;
    end
`endif

    // Outstanding read counter; a simultaneous accept and return cancel.
    always_comb begin
        pending_d = pending_q;
        if (rd_accept && !pending_dec && pending_q != PEND_MAX) begin
            pending_d = pending_q + PEND_W'(1);
        end else if (pending_dec && !rd_accept && pending_q != '0) begin
            pending_d = pending_q - PEND_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rest) begin
        if (rest) begin
            pending_q  <= '0;
            last_cmd_q <= '0;
            rst_busy_q <= 1'b1;
        end else begin
            pending_q  <= pending_d;
            last_cmd_q <= last_cmd_d;
            rst_busy_q <= rst_busy_d;
        end
    end

endmodule

// File: tb/tb_avl_bus_pipe_bridge.sv
// Directed testbench for avl_bus_pipe_bridge. Inputs are driven on the
// falling edge and outputs sampled 1 ns later, away from the rising edge.
module tb_avl_bus_pipe_bridge;

`ifdef AVL_BUS_PIPE_BRIDGE_RDATA_REG_EN
    localparam int L = 1;
`else
    localparam int L = 0;
`endif

    logic        clk;
    logic        rest;
    logic [31:0] s_address;
    logic        s_read;
    logic        s_write;
    logic [31:0] s_writedata;
    logic [3:0]  s_byteenable;
    logic        s_waitrequest;
    logic [31:0] s_readdata;
    logic        s_readdatavalid;
    logic [31:0] m_address;
    logic        m_read;
    logic        m_write;
    logic [31:0] m_writedata;
    logic [3:0]  m_byteenable;
    logic        m_waitrequest;
    logic [31:0] m_readdata;
    logic        m_readdatavalid;

    int errors = 0;
    int checks = 0;

    avl_bus_pipe_bridge dut (
        .clk             (clk),
        .rest            (rest),
        .s_address       (s_address),
        .s_read          (s_read),
        .s_write         (s_write),
        .s_writedata     (s_writedata),
        .s_byteenable    (s_byteenable),
        .s_waitrequest   (s_waitrequest),
        .s_readdata      (s_readdata),
        .s_readdatavalid (s_readdatavalid),
        .m_address       (m_address),
        .m_read          (m_read),
        .m_write         (m_write),
        .m_writedata     (m_writedata),
        .m_byteenable    (m_byteenable),
        .m_waitrequest   (m_waitrequest),
        .m_readdata      (m_readdata),
        .m_readdatavalid (m_readdatavalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic idle_inputs();
        s_read          = 1'b0;
        s_write         = 1'b0;
        s_address       = '0;
        s_writedata     = '0;
        s_byteenable    = '0;
        m_readdatavalid = 1'b0;
        m_readdata      = '0;
    endtask

    task automatic test_reset();
        rest          = 1'b1;
        m_waitrequest = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        checks++; if (s_waitrequest !== 1'b1) begin errors++; $display("[TB] FAIL reset_waitreq: got %0b expected 1", s_waitrequest); end
        checks++; if (s_readdatavalid !== 1'b0) begin errors++; $display("[TB] FAIL reset_rdv: got %0b expected 0", s_readdatavalid); end
        checks++; if (s_readdata !== 32'h0) begin errors++; $display("[TB] FAIL reset_rdata: got %h expected 0", s_readdata); end
        checks++; if (m_read !== 1'b0 || m_write !== 1'b0) begin errors++; $display("[TB] FAIL reset_mcmd: got rd=%0b wr=%0b expected 0/0", m_read, m_write); end
        checks++; if (m_address !== 32'h0 || m_writedata !== 32'h0 || m_byteenable !== 4'h0) begin errors++; $display("[TB] FAIL reset_mbus: got a=%h d=%h be=%h expected zeros", m_address, m_writedata, m_byteenable); end
        rest = 1'b0; #1;
        checks++; if (s_waitrequest !== 1'b1) begin errors++; $display("[TB] FAIL release_waitreq_hold: got %0b expected 1", s_waitrequest); end
        @(negedge clk); #1;
        checks++; if (s_waitrequest !== 1'b0) begin errors++; $display("[TB] FAIL release_waitreq_clear: got %0b expected 0", s_waitrequest); end
    endtask

    task automatic test_back_to_back();
        m_waitrequest = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            s_write      = 1'b1;
            s_address    = 32'(32'h10 + k);
            s_writedata  = 32'(32'h1000 + k);
            s_byteenable = 4'hF;
            #1;
            checks++; if (s_waitrequest !== 1'b0) begin errors++; $display("[TB] FAIL b2b_waitreq[%0d]: got %0b expected 0", k, s_waitrequest); end
            checks++; if (m_write !== (k > 0)) begin errors++; $display("[TB] FAIL b2b_mwrite[%0d]: got %0b expected %0b", k, m_write, (k > 0)); end
            if (k > 0) begin
                checks++; if (m_address !== 32'(32'h10 + k - 1)) begin errors++; $display("[TB] FAIL b2b_maddr[%0d]: got %h expected %h", k, m_address, 32'(32'h10 + k - 1)); end
            end
        end
        @(negedge clk);
        idle_inputs(); #1;
        checks++; if (m_write !== 1'b1 || m_address !== 32'h13) begin errors++; $display("[TB] FAIL b2b_last: got wr=%0b a=%h expected 1/13", m_write, m_address); end
        checks++; if (m_writedata !== 32'h1003 || m_byteenable !== 4'hF) begin errors++; $display("[TB] FAIL b2b_last_data: got d=%h be=%h expected 1003/f", m_writedata, m_byteenable); end
        @(negedge clk); #1;
        checks++; if (m_write !== 1'b0 || m_address !== 32'h13) begin errors++; $display("[TB] FAIL b2b_empty_hold: got wr=%0b a=%h expected 0/13", m_write, m_address); end
    endtask

    task automatic test_fifo_full();
        logic [31:0] exp_addr [3];
        exp_addr[0] = 32'h32; exp_addr[1] = 32'h33; exp_addr[2] = 32'h34;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            m_waitrequest = 1'b1;
            s_write       = 1'b1;
            s_address     = 32'(32'h30 + k);
            s_writedata   = 32'(32'h3000 + k);
            s_byteenable  = 4'h3;
            #1;
            checks++; if (s_waitrequest !== 1'b0) begin errors++; $display("[TB] FAIL full_fill[%0d]: got %0b expected 0", k, s_waitrequest); end
        end
        @(negedge clk);
        s_address = 32'h34; #1;
        checks++; if (s_waitrequest !== 1'b1) begin errors++; $display("[TB] FAIL full_stall: got %0b expected 1", s_waitrequest); end
        checks++; if (m_write !== 1'b1 || m_address !== 32'h30) begin errors++; $display("[TB] FAIL full_head: got wr=%0b a=%h expected 1/30", m_write, m_address); end
        @(negedge clk);
        m_waitrequest = 1'b0; #1;
        checks++; if (s_waitrequest !== 1'b1) begin errors++; $display("[TB] FAIL full_pop_push_refused: got %0b expected 1", s_waitrequest); end
        @(negedge clk); #1;
        checks++; if (s_waitrequest !== 1'b0 || m_address !== 32'h31) begin errors++; $display("[TB] FAIL full_after_pop: got wr=%0b a=%h expected 0/31", s_waitrequest, m_address); end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            idle_inputs(); #1;
            checks++; if (m_write !== 1'b1 || m_address !== exp_addr[k]) begin errors++; $display("[TB] FAIL full_order[%0d]: got wr=%0b a=%h expected 1/%h", k, m_write, m_address, exp_addr[k]); end
        end
        @(negedge clk); #1;
        checks++; if (m_write !== 1'b0) begin errors++; $display("[TB] FAIL full_drained: got %0b expected 0", m_write); end
    endtask

    task automatic test_read_limit();
        int          rdv_cycle;
        int          free_cycle;
        logic [31:0] rdv_data;
        logic        exp_v;
        int          idx;
        m_waitrequest = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            s_read    = 1'b1;
            s_address = 32'(32'h40 + k);
            #1;
            checks++; if (s_waitrequest !== 1'b0) begin errors++; $display("[TB] FAIL rdlim_accept[%0d]: got %0b expected 0", k, s_waitrequest); end
            if (k == 1) begin
                checks++; if (m_read !== 1'b1 || m_address !== 32'h40) begin errors++; $display("[TB] FAIL rdlim_mread: got rd=%0b a=%h expected 1/40", m_read, m_address); end
            end
        end
        @(negedge clk);
        s_address = 32'h44; #1;
        checks++; if (s_waitrequest !== 1'b1) begin errors++; $display("[TB] FAIL rdlim_stall: got %0b expected 1", s_waitrequest); end
        rdv_cycle  = -1;
        free_cycle = -1;
        rdv_data   = '0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            m_readdatavalid = (c == 0);
            m_readdata      = 32'hA5A5_0001;
            #1;
            if (s_readdatavalid === 1'b1 && rdv_cycle < 0) begin rdv_cycle = c; rdv_data = s_readdata; end
            if (s_waitrequest === 1'b0 && free_cycle < 0) free_cycle = c;
        end
        #1;
        checks++; if (rdv_cycle !== L) begin errors++; $display("[TB] FAIL rdlim_rdv_latency: got %0d expected %0d", rdv_cycle, L); end
        checks++; if (rdv_data !== 32'hA5A5_0001) begin errors++; $display("[TB] FAIL rdlim_rdata: got %h expected a5a50001", rdv_data); end
        checks++; if (free_cycle !== 1 + L) begin errors++; $display("[TB] FAIL rdlim_slot_free: got %0d expected %0d", free_cycle, 1 + L); end
        checks++; if (s_waitrequest !== 1'b1) begin errors++; $display("[TB] FAIL rdlim_refill: got %0b expected 1", s_waitrequest); end
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            s_read          = 1'b0;
            m_readdatavalid = (k < 5);
            m_readdata      = 32'(32'hB000 + k);
            #1;
            idx   = k - L;
            exp_v = (idx >= 0) && (idx < 4);
            checks++; if (s_readdatavalid !== exp_v) begin errors++; $display("[TB] FAIL drain_rdv[%0d]: got %0b expected %0b", k, s_readdatavalid, exp_v); end
            if (exp_v) begin
                checks++; if (s_readdata !== 32'(32'hB000 + idx)) begin errors++; $display("[TB] FAIL drain_rdata[%0d]: got %h expected %h", k, s_readdata, 32'(32'hB000 + idx)); end
            end
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_read_return_overlap();
        int          rdv_cycle;
        logic [31:0] rdv_data;
        int          accepts;
        m_waitrequest = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            s_read    = 1'b1;
            s_address = 32'(32'h50 + k);
            #1;
            checks++; if (s_waitrequest !== 1'b0) begin errors++; $display("[TB] FAIL ovl_accept[%0d]: got %0b expected 0", k, s_waitrequest); end
        end
        rdv_cycle = -1;
        rdv_data  = '0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            s_read          = (c == 0);
            s_address       = 32'h52;
            m_readdatavalid = (c == 0);
            m_readdata      = 32'hC0DE_0001;
            #1;
            if (c == 0) begin
                checks++; if (s_waitrequest !== 1'b0) begin errors++; $display("[TB] FAIL ovl_simul_accept: got %0b expected 0", s_waitrequest); end
            end
            if (s_readdatavalid === 1'b1 && rdv_cycle < 0) begin rdv_cycle = c; rdv_data = s_readdata; end
        end
        checks++; if (rdv_cycle !== L || rdv_data !== 32'hC0DE_0001) begin errors++; $display("[TB] FAIL ovl_return: got cyc=%0d d=%h expected %0d/c0de0001", rdv_cycle, rdv_data, L); end
        accepts = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            s_read    = 1'b1;
            s_address = 32'(32'h58 + k);
            #1;
            if (s_waitrequest) break;
            accepts++;
        end
        checks++; if (accepts !== 2) begin errors++; $display("[TB] FAIL ovl_pending_kept: got %0d free slots expected 2", accepts); end
        s_read = 1'b0;
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        idle_inputs();
        rest = 1'b1;
        @(negedge clk);
        rest = 1'b0;
        @(negedge clk);
        m_waitrequest = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            s_read    = 1'b1;
            s_address = 32'(32'h60 + k);
        end
        @(negedge clk);
        idle_inputs();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            m_waitrequest = 1'b1;
            s_write       = 1'b1;
            s_address     = 32'(32'h70 + k);
            s_writedata   = 32'(32'h7000 + k);
        end
        @(negedge clk);
        idle_inputs(); #1;
        checks++; if (m_write !== 1'b1 || m_address !== 32'h70) begin errors++; $display("[TB] FAIL rstmid_queued: got wr=%0b a=%h expected 1/70", m_write, m_address); end
        rest = 1'b1; #1;
        checks++; if (m_read !== 1'b0 || m_write !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_mcmd: got rd=%0b wr=%0b expected 0/0", m_read, m_write); end
        checks++; if (s_waitrequest !== 1'b1 || m_address !== 32'h0) begin errors++; $display("[TB] FAIL rstmid_state: got wait=%0b a=%h expected 1/0", s_waitrequest, m_address); end
        @(negedge clk);
        rest          = 1'b0;
        m_waitrequest = 1'b0;
        @(negedge clk);
        m_readdatavalid = 1'b1;
        m_readdata      = 32'hDEAD_BEEF;
        #1;
        checks++; if (s_readdatavalid !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_stale0: got %0b expected 0", s_readdatavalid); end
        @(negedge clk);
        m_readdatavalid = 1'b0; #1;
        checks++; if (s_readdatavalid !== 1'b0 || m_write !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_stale1: got rdv=%0b wr=%0b expected 0/0", s_readdatavalid, m_write); end
    endtask

    task automatic test_read_write_both();
        int accepts;
        m_waitrequest = 1'b0;
        @(negedge clk);
        s_read       = 1'b1;
        s_write      = 1'b1;
        s_address    = 32'h20;
        s_writedata  = 32'h2020;
        s_byteenable = 4'h5;
        #1;
        checks++; if (s_waitrequest !== 1'b0) begin errors++; $display("[TB] FAIL rw_accept: got %0b expected 0", s_waitrequest); end
        @(negedge clk);
        idle_inputs(); #1;
        checks++; if (m_write !== 1'b1 || m_read !== 1'b0 || m_address !== 32'h20) begin errors++; $display("[TB] FAIL rw_cmd: got wr=%0b rd=%0b a=%h expected 1/0/20", m_write, m_read, m_address); end
        checks++; if (m_writedata !== 32'h2020 || m_byteenable !== 4'h5) begin errors++; $display("[TB] FAIL rw_data: got d=%h be=%h expected 2020/5", m_writedata, m_byteenable); end
        @(negedge clk); #1;
        checks++; if (m_write !== 1'b0 || m_read !== 1'b0) begin errors++; $display("[TB] FAIL rw_single: got wr=%0b rd=%0b expected 0/0", m_write, m_read); end
        accepts = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            s_read    = 1'b1;
            s_address = 32'(32'h80 + k);
            #1;
            if (s_waitrequest) break;
            accepts++;
        end
        checks++; if (accepts !== 4) begin errors++; $display("[TB] FAIL rw_pending_unchanged: got %0d free slots expected 4", accepts); end
        s_read = 1'b0;
    endtask

    initial begin
        $display("[TB] avl_bus_pipe_bridge bench, read return latency %0d", L);
        test_reset();
        test_back_to_back();
        test_fifo_full();
        test_read_limit();
        test_read_return_overlap();
        test_reset_mid();
        test_read_write_both();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
